// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit beside Execute
// Optional result reuse cache enabled by defining MULDIV_RESULT_REUSE_EN.
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int RD_W           = 5
) (
  input  logic            clk,
  input  logic            asrst_n,
  input  logic            flush,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [RD_W-1:0] req_rd,
  output logic            resp_vld,
  output logic [RD_W-1:0] resp_rd,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d, result_q, result_d;
  logic            neg_q, neg_d, rneg_q, rneg_d;

  logic            accept, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;
  logic [XLEN-1:0] step_hi, step_lo, quo_fix, rem_fix, fix_hi, fix_lo;
  logic [XLEN:0]   sum, shf, diff;
  logic [2*XLEN-1:0] prod, prod_fix;

  // Result select: MUL takes the low half, MULH* the high half; REM* takes remainder.
  function automatic logic [XLEN-1:0] pick(input logic [2:0] op,
                                           input logic [XLEN-1:0] hi,
                                           input logic [XLEN-1:0] lo);
    if (op[2]) return op[1] ? hi : lo;
    return (op[1:0] == 2'b00) ? lo : hi;
  endfunction

`ifdef MULDIV_RESULT_REUSE_EN
  logic            c_vld_q, c_vld_d, hit;
  logic [2:0]      c_op_q, c_op_d;
  logic [XLEN-1:0] c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d, c_hi_q, c_hi_d, c_lo_q, c_lo_d;

  assign hit = c_vld_q && (req_rs1 == c_rs1_q) && (req_rs2 == c_rs2_q) &&
               (req_op[2] ? (c_op_q[2] && (c_op_q[0] == req_op[0]))
                          : (!c_op_q[2] && ((c_op_q[1:0] == req_op[1:0]) || (req_op[1:0] == 2'b00))));
`endif

  assign req_rdy   = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign resp_vld  = (state_q == S_DONE) && !flush;
  assign resp_rd   = rd_q;
  assign resp_data = result_q;
  assign accept    = req_vld && req_rdy && !flush;

  always_comb begin
    a_sgn    = req_op[2] ? ~req_op[0] : ((req_op[1:0] == 2'b01) || (req_op[1:0] == 2'b10));
    b_sgn    = req_op[2] ? ~req_op[0] : (req_op[1:0] == 2'b01);
    a_neg    = a_sgn & req_rs1[XLEN-1];
    b_neg    = b_sgn & req_rs2[XLEN-1];
    a_mag    = a_neg ? -req_rs1 : req_rs1;
    b_mag    = b_neg ? -req_rs2 : req_rs2;
    div_zero = req_op[2] && (req_rs2 == '0);
    div_ovf  = req_op[2] && !req_op[0] && (req_rs1 == MIN) && (req_rs2 == ONES);
    fast_res = div_zero ? (req_op[1] ? req_rs1 : ONES) : (req_op[1] ? '0 : req_rs1);
  end

  // hi/lo hold {partial product, multiplier} for mul and {remainder, quotient} for div.
  always_comb begin
    step_hi = hi_q;
    step_lo = lo_q;
    sum     = '0;
    shf     = '0;
    diff    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        shf  = {step_hi, step_lo[XLEN-1]};
        diff = shf - {1'b0, dvs_q};
        if (!diff[XLEN]) begin
          step_hi = diff[XLEN-1:0];
          step_lo = {step_lo[XLEN-2:0], 1'b1};
        end else begin
          step_hi = shf[XLEN-1:0];
          step_lo = {step_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, dvs_q} : '0);
        step_lo = {sum[0], step_lo[XLEN-1:1]};
        step_hi = sum[XLEN:1];
      end
    end
  end

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = rneg_q ? -hi_q : hi_q;
    fix_hi   = op_q[2] ? rem_fix : prod_fix[2*XLEN-1:XLEN];
    fix_lo   = op_q[2] ? quo_fix : prod_fix[XLEN-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dvs_d    = dvs_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
`ifdef MULDIV_RESULT_REUSE_EN
    c_vld_d  = c_vld_q;
    c_op_d   = c_op_q;
    c_rs1_d  = c_rs1_q;
    c_rs2_d  = c_rs2_q;
    c_hi_d   = c_hi_q;
    c_lo_d   = c_lo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = req_op;
          rd_d = req_rd;
          if (div_zero || div_ovf) begin
            result_d = fast_res;
            state_d  = S_DONE;
`ifdef MULDIV_RESULT_REUSE_EN
          end else if (hit) begin
            result_d = pick(req_op, c_hi_q, c_lo_q);
            state_d  = S_DONE;
`endif
          end else begin
            state_d = S_CALC;
            cnt_d   = CNT_W'(N - 1);
            hi_d    = '0;
            lo_d    = a_mag;
            dvs_d   = b_mag;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
`ifdef MULDIV_RESULT_REUSE_EN
            c_vld_d = 1'b0;
            c_op_d  = req_op;
            c_rs1_d = req_rs1;
            c_rs2_d = req_rs2;
`endif
          end
        end
      end
      S_CALC: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FIX: begin
        result_d = pick(op_q, fix_hi, fix_lo);
        state_d  = S_DONE;
`ifdef MULDIV_RESULT_REUSE_EN
        c_vld_d  = 1'b1;
        c_hi_d   = fix_hi;
        c_lo_d   = fix_lo;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
`ifdef MULDIV_RESULT_REUSE_EN
      c_vld_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge asrst_n) begin
    if (!asrst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
`ifdef MULDIV_RESULT_REUSE_EN
      c_vld_q  <= 1'b0;
      c_op_q   <= '0;
      c_rs1_q  <= '0;
      c_rs2_q  <= '0;
      c_hi_q   <= '0;
      c_lo_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dvs_q    <= dvs_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
`ifdef MULDIV_RESULT_REUSE_EN
      c_vld_q  <= c_vld_d;
      c_op_q   <= c_op_d;
      c_rs1_q  <= c_rs1_d;
      c_rs2_q  <= c_rs2_d;
      c_hi_q   <= c_hi_d;
      c_lo_q   <= c_lo_d;
`endif
    end
  end

endmodule
